apb_arbiter: RTL and testbench
==============================

# apb_arbiter

Two-master APB arbiter that shares the single APB slave bus (RAM and future peripherals) between the core's memory port (master 0) and a second requester such as a debug/DMA engine (master 1). Each upstream master sees a standard APB slave port. The arbiter picks one master per transfer with round-robin fairness and replays that transfer on the downstream bus. It returns `pready`, `prdata` and `pslverr` only to the granted master.

## Interface
Parameters:
- `ADDR_W`, 32, address width on all ports.
- `DATA_W`, 32, data width; `pwstrb` width is `DATA_W/8`.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `m0_psel`, `m0_penable`, `m0_pwrite`  in  1 each  master 0 APB controls.
- `m0_paddr`  in  ADDR_W  master 0 address.
- `m0_pwdata`  in  DATA_W  master 0 write data.
- `m0_pwstrb`  in  DATA_W/8  master 0 byte strobes.
- `m0_pready`, `m0_pslverr`  out  1 each  master 0 completion and error.
- `m0_prdata`  out  DATA_W  master 0 read data.
- `m1_*`  same set as `m0_*`  master 1.
- `psel`, `penable`, `pwrite`  out  1 each  downstream APB controls.
- `paddr`  out  ADDR_W  downstream address.
- `pwdata`  out  DATA_W  downstream write data.
- `pwstrb`  out  DATA_W/8  downstream byte strobes.
- `pready`, `pslverr`  in  1 each  downstream completion and error.
- `prdata`  in  DATA_W  downstream read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Grant register `gnt` (0/1). Round-robin pointer `last` (last master served).
- IDLE:
  - If only one `mX_psel` is high, `gnt`←X and go to SETUP.
  - If both are high, `gnt`←`!last` and go to SETUP.
  - If neither is high, stay in IDLE.
- SETUP: `psel`=1, `penable`=0. Always go to ACCESS next cycle.
- ACCESS: `psel`=1, `penable`=1.
  - On `pready`=1: `m[gnt]_pready`=1 this cycle, `last`←`gnt`, go to IDLE.
  - Otherwise stay in ACCESS.
- Downstream `paddr`/`pwrite`/`pwdata`/`pwstrb` are combinationally muxed from master `gnt` in SETUP/ACCESS. In IDLE they are 0.
- `m[gnt]_prdata`/`m[gnt]_pslverr` pass through from downstream. The non-granted master sees `pready`=0, `pslverr`=0, `prdata`=0.
- A master that is not granted sits in its own ACCESS phase with `pready`=0 until it is served. No request is ever dropped.
- `pslverr` is forwarded unchanged. The arbiter never generates errors itself.
- A master deasserting `psel` mid-transfer is a protocol violation. The arbiter still completes the downstream transfer and returns to IDLE. The bench flags this with an assertion.

## Timing
- Reset (async assert, sync deassert by system):
  - state=IDLE, `gnt`=0, `last`=1, so master 0 wins the first tie.
  - All outputs are 0.
- Latency: master SETUP seen in cycle N → downstream SETUP in N+1 → downstream ACCESS in N+2. Master `pready` follows downstream `pready` in the same cycle, so a zero-wait slave completes in N+2.
- Minimum one IDLE cycle between downstream transfers. Back-to-back requests from both masters alternate 0,1,0,1…
- Downstream APB rules hold: address/control stable from SETUP through completion, and `penable` is low in SETUP.
- Reset asserted mid-transfer: immediately IDLE with all outputs 0. The in-flight transfer is abandoned, and masters must be reset by the same `rst_n`.

## Structure
- Package `apb_arb_pkg`:
  - `apb_arb_state_e` enum {IDLE, SETUP, ACCESS}.
  - Localparams `M_CORE`=0 and `M_AUX`=1.
- Sub-module `apb_arb_rr`: combinational 2-way round-robin pick.
  - Inputs `req[1:0]`, `last`.
  - Outputs `valid`, `idx`.
- Top module `apb_arbiter`: FSM, `gnt`/`last` registers, datapath muxes. Target about 150–250 lines.

## Test plan
- Single master 0 read of 0x100 with zero-wait slave returning 0xDEADBEEF → downstream SETUP 1 cycle after request. `m0_pready`=1 and `m0_prdata`=0xDEADBEEF 2 cycles after request. `m1_pready` stays 0.
- Simultaneous request after reset: m0 write 0x10←0x11111111, m1 write 0x20←0x22222222 → m0 served first, then m1. Each has 1 IDLE gap. RAM holds both values.
- Both masters requesting continuously for 6 transfers → grant order 0,1,0,1,0,1. Neither master waits more than one other transfer.
- Slave inserts 3 wait states with `pslverr`=1 on m1 read of 0x30 → `penable` high for 4 cycles with address stable. `m1_pready`=`m1_pslverr`=1 on the final cycle. m0 unaffected.
- `rst_n` pulled low during downstream ACCESS → `psel`/`penable`/all `mX_pready` go 0 asynchronously. After release, m0 wins the first tie again.
- Byte write m1 `pwstrb`=4'b0100 to 0x40 with data 0xAABBCCDD, then read 0x40 → only byte 2 updated (0x00BB0000 over zeroed RAM).

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and master indices for the two-master APB arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

  // Master 0 is the core memory port, master 1 the auxiliary (debug/DMA) port.
  localparam logic M_CORE = 1'b0;
  localparam logic M_AUX  = 1'b1;

endpackage

// File: rtl/apb_arb_rr.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the master that was not served last.
module apb_arb_rr
  import apb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  // Combinational pick of the next master to serve.
  always_comb begin
    valid = |req;
    idx   = M_CORE;
    if (req == 2'b11) begin
      idx = ~last;
    end else if (req[1]) begin
      idx = M_AUX;
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Two-master APB arbiter: replays one granted master transfer at a time on
// the shared downstream APB bus, returning completion only to that master.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // master 0
  input  logic                m0_psel,
  input  logic                m0_penable,
  input  logic                m0_pwrite,
  input  logic [ADDR_W-1:0]   m0_paddr,
  input  logic [DATA_W-1:0]   m0_pwdata,
  input  logic [DATA_W/8-1:0] m0_pwstrb,
  output logic                m0_pready,
  output logic                m0_pslverr,
  output logic [DATA_W-1:0]   m0_prdata,
  // master 1
  input  logic                m1_psel,
  input  logic                m1_penable,
  input  logic                m1_pwrite,
  input  logic [ADDR_W-1:0]   m1_paddr,
  input  logic [DATA_W-1:0]   m1_pwdata,
  input  logic [DATA_W/8-1:0] m1_pwstrb,
  output logic                m1_pready,
  output logic                m1_pslverr,
  output logic [DATA_W-1:0]   m1_prdata,
  // downstream slave bus
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pwstrb,
  input  logic                pready,
  input  logic                pslverr,
  input  logic [DATA_W-1:0]   prdata
);

  apb_arb_state_e state_reg, state_next;
  logic           gnt_reg, gnt_next;
  logic           last_reg, last_next;
  logic           pick_valid, pick_idx;
  logic           busy, done;

  // Master penable is not needed: a held psel already marks a pending request.
  logic unused_penable;
  assign unused_penable = &{1'b0, m0_penable, m1_penable};

  apb_arb_rr u_rr (
    .req   ({m1_psel, m0_psel}),
    .last  (last_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // State, grant and round-robin history registers; last starts at 1 so
  // master 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= M_CORE;
      last_reg  <= M_AUX;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
    end
  end

  // Next-state logic: latch a grant in IDLE, always one SETUP cycle, then
  // hold ACCESS until the slave completes.
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          gnt_next   = pick_idx;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          last_next  = gnt_reg;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy    = (state_reg != IDLE);
  assign psel    = busy;
  assign penable = (state_reg == ACCESS);
  assign done    = penable & pready;

  // Downstream request mux from the granted master; quiet bus while idle.
  always_comb begin
    pwrite = 1'b0;
    paddr  = '0;
    pwdata = '0;
    pwstrb = '0;
    if (busy) begin
      pwrite = gnt_reg ? m1_pwrite : m0_pwrite;
      paddr  = gnt_reg ? m1_paddr  : m0_paddr;
      pwdata = gnt_reg ? m1_pwdata : m0_pwdata;
      pwstrb = gnt_reg ? m1_pwstrb : m0_pwstrb;
    end
  end

  // Response demux: only the granted master sees the slave's response.
  always_comb begin
    m0_pready  = 1'b0;
    m0_pslverr = 1'b0;
    m0_prdata  = '0;
    m1_pready  = 1'b0;
    m1_pslverr = 1'b0;
    m1_prdata  = '0;
    if (busy && (gnt_reg == M_CORE)) begin
      m0_pready  = done;
      m0_pslverr = pslverr;
      m0_prdata  = prdata;
    end
    if (busy && (gnt_reg == M_AUX)) begin
      m1_pready  = done;
      m1_pslverr = pslverr;
      m1_prdata  = prdata;
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed scenarios plus randomized
// rounds, checked cycle by cycle against a schedule derived from the
// arbitration and timing rules, with a RAM slave and a reference memory.
module tb_apb_arbiter;

  logic        clk, rst_n;
  logic        m0_psel, m0_penable, m0_pwrite;
  logic [31:0] m0_paddr, m0_pwdata;
  logic [3:0]  m0_pwstrb;
  logic        m0_pready, m0_pslverr;
  logic [31:0] m0_prdata;
  logic        m1_psel, m1_penable, m1_pwrite;
  logic [31:0] m1_paddr, m1_pwdata;
  logic [3:0]  m1_pwstrb;
  logic        m1_pready, m1_pslverr;
  logic [31:0] m1_prdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pwstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;

  apb_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pwstrb(m0_pwstrb),
    .m0_pready(m0_pready), .m0_pslverr(m0_pslverr), .m0_prdata(m0_prdata),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pwstrb(m1_pwstrb),
    .m1_pready(m1_pready), .m1_pslverr(m1_pslverr), .m1_prdata(m1_prdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pwstrb(pwstrb),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wcnt;
    logic        err;
  } xfer_t;

  xfer_t       d[2];
  logic [31:0] slave_mem [256];
  logic [31:0] ref_mem   [256];
  int          vectors = 0;
  int          errors  = 0;
  int          last_m  = 1;
  int          served[$];
  logic [31:0] last_rd;
  bit          pend[2];

  // Masters must hold psel until their transfer completes.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!pend[0] || m0_psel) else $error("protocol violation: m0 dropped psel mid-transfer");
      assert (!pend[1] || m1_psel) else $error("protocol violation: m1 dropped psel mid-transfer");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_desc(input int m, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st,
                          input int wc, input logic er);
    d[m].write = wr; d[m].addr = a; d[m].wdata = wd;
    d[m].strb = st; d[m].wcnt = wc; d[m].err = er;
  endtask

  task automatic rand_desc(input int m);
    logic wr;
    wr = 1'($urandom_range(0, 1));
    set_desc(m, wr, 32'($urandom_range(0, 255)) << 2, $urandom,
             wr ? 4'($urandom_range(1, 15)) : 4'h0,
             $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
  endtask

  task automatic issue(input int m);
    if (m == 0) begin
      m0_psel = 1; m0_penable = 0; m0_pwrite = d[0].write; m0_paddr = d[0].addr;
      m0_pwdata = d[0].wdata; m0_pwstrb = d[0].strb;
    end else begin
      m1_psel = 1; m1_penable = 0; m1_pwrite = d[1].write; m1_paddr = d[1].addr;
      m1_pwdata = d[1].wdata; m1_pwstrb = d[1].strb;
    end
    pend[m] = 1;
  endtask

  task automatic release_m(input int m);
    if (m == 0) begin
      m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = 0; m0_pwdata = 0; m0_pwstrb = 0;
    end else begin
      m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = 0; m1_pwdata = 0; m1_pwstrb = 0;
    end
    pend[m] = 0;
  endtask

  // One bus cycle, entered at a falling edge. ph: 0 idle, 1 setup, 2 access.
  task automatic cycle(input int ph, input int srv, input bit done);
    logic [31:0] exp_rd;
    if (ph == 0) begin
      pready = 0; pslverr = 0; prdata = 0;
    end else begin
      pready  = (ph == 2) && done;
      pslverr = done ? d[srv].err : 1'($urandom_range(0, 1));
      prdata  = $urandom;
      if (done && !pwrite) prdata = slave_mem[paddr[9:2]];
    end
    #1;
    chk("psel",    32'(psel),    32'(ph != 0));
    chk("penable", 32'(penable), 32'(ph == 2));
    chk("paddr",   paddr,          (ph != 0) ? d[srv].addr : 32'h0);
    chk("pwrite",  32'(pwrite),    (ph != 0) ? 32'(d[srv].write) : 32'h0);
    chk("pwdata",  pwdata,         (ph != 0) ? d[srv].wdata : 32'h0);
    chk("pwstrb",  32'(pwstrb),    (ph != 0) ? 32'(d[srv].strb) : 32'h0);
    for (int m = 0; m < 2; m++) begin
      bit g;
      g = (ph != 0) && (m == srv);
      chk($sformatf("m%0d_pready", m),  32'(m ? m1_pready : m0_pready),   32'(g && done));
      chk($sformatf("m%0d_pslverr", m), 32'(m ? m1_pslverr : m0_pslverr), g ? 32'(pslverr) : 32'h0);
      chk($sformatf("m%0d_prdata", m),  m ? m1_prdata : m0_prdata,        g ? prdata : 32'h0);
    end
    if (done) begin
      if (pwrite) begin
        for (int b = 0; b < 4; b++)
          if (pwstrb[b]) slave_mem[paddr[9:2]][8*b +: 8] = pwdata[8*b +: 8];
      end
      if (d[srv].write) begin
        for (int b = 0; b < 4; b++)
          if (d[srv].strb[b]) ref_mem[d[srv].addr[9:2]][8*b +: 8] = d[srv].wdata[8*b +: 8];
      end else begin
        exp_rd  = ref_mem[d[srv].addr[9:2]];
        last_rd = srv ? m1_prdata : m0_prdata;
        chk("read_data", last_rd, exp_rd);
      end
      last_m = srv;
      served.push_back(srv);
      $display("xfer m%0d %s addr=%h data=%h err=%0d", srv, d[srv].write ? "WR" : "RD",
               d[srv].addr, d[srv].write ? d[srv].wdata : last_rd, d[srv].err);
    end
  endtask

  // Requesters raise psel together; the expected service order comes from
  // the round-robin rule applied to the bench's own history.
  task automatic run_round(input bit r0, input bit r1);
    int order[$];
    if (r0 && r1) begin
      order.push_back(last_m == 1 ? 0 : 1);
      order.push_back(last_m == 1 ? 1 : 0);
    end else begin
      order.push_back(r0 ? 0 : 1);
    end
    @(negedge clk);
    if (r0) issue(0);
    if (r1) issue(1);
    cycle(0, 0, 0);
    @(negedge clk);
    if (r0) m0_penable = 1;
    if (r1) m1_penable = 1;
    foreach (order[k]) begin
      if (k > 0) @(negedge clk);
      cycle(1, order[k], 0);
      for (int w = 0; w <= d[order[k]].wcnt; w++) begin
        @(negedge clk);
        cycle(2, order[k], w == d[order[k]].wcnt);
      end
      @(negedge clk);
      release_m(order[k]);
      cycle(0, 0, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    release_m(0); release_m(1);
    pready = 0; pslverr = 0; prdata = 0;
    @(negedge clk);
    rst_n = 1;
    last_m = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 32'h0;
      ref_mem[i]   = 32'h0;
    end
    rst_n = 0;
    release_m(0); release_m(1);
    pready = 1; pslverr = 1; prdata = 32'hFFFF_FFFF;
    #2;
    // reset state: quiet bus, nothing returned to either master
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_m0_pready", 32'(m0_pready), 32'h0);
    chk("rst_m1_pready", 32'(m1_pready), 32'h0);
    chk("rst_m0_prdata", m0_prdata, 32'h0);
    chk("rst_m1_pslverr", 32'(m1_pslverr), 32'h0);
    pready = 0; pslverr = 0; prdata = 0;
    @(negedge clk);
    rst_n = 1;

    // zero-wait read of 0x100 by master 0
    slave_mem[64] = 32'hDEADBEEF;
    ref_mem[64]   = 32'hDEADBEEF;
    set_desc(0, 0, 32'h100, 32'h0, 4'h0, 0, 0);
    run_round(1, 0);
    chk("t1_rdata", last_rd, 32'hDEADBEEF);

    // simultaneous writes after reset: master 0 first
    do_reset();
    served.delete();
    set_desc(0, 1, 32'h10, 32'h11111111, 4'hF, 0, 0);
    set_desc(1, 1, 32'h20, 32'h22222222, 4'hF, 0, 0);
    run_round(1, 1);
    chk("t2_first", 32'(served[0]), 32'h0);
    chk("t2_second", 32'(served[1]), 32'h1);
    chk("t2_ram10", slave_mem[4], 32'h11111111);
    chk("t2_ram20", slave_mem[8], 32'h22222222);

    // byte write on lane 2 then read back over zeroed RAM
    set_desc(1, 1, 32'h40, 32'hAABBCCDD, 4'b0100, 0, 0);
    run_round(0, 1);
    set_desc(1, 0, 32'h40, 32'h0, 4'h0, 1, 0);
    run_round(0, 1);
    chk("t6_byte", last_rd, 32'h00BB0000);

    // master 1 read with 3 wait states and an error response
    set_desc(1, 0, 32'h30, 32'h0, 4'h0, 3, 1);
    run_round(0, 1);

    // continuous contention: alternation from a master-0 start
    do_reset();
    served.delete();
    for (int r = 0; r < 3; r++) begin
      rand_desc(0);
      rand_desc(1);
      run_round(1, 1);
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_order%0d", i), 32'(served[i]), 32'(i % 2));

    // reset asserted during downstream ACCESS
    set_desc(0, 0, 32'h100, 32'h0, 4'h0, 3, 0);
    @(negedge clk);
    issue(0);
    cycle(0, 0, 0);
    @(negedge clk);
    m0_penable = 1;
    cycle(1, 0, 0);
    @(negedge clk);
    cycle(2, 0, 0);
    #1;
    pready = 1;
    rst_n = 0;
    #1;
    chk("t5_psel", 32'(psel), 32'h0);
    chk("t5_penable", 32'(penable), 32'h0);
    chk("t5_m0_pready", 32'(m0_pready), 32'h0);
    chk("t5_m1_pready", 32'(m1_pready), 32'h0);
    release_m(0); release_m(1);
    pready = 0;
    @(negedge clk);
    rst_n = 1;
    last_m = 1;
    served.delete();
    rand_desc(0);
    rand_desc(1);
    run_round(1, 1);
    chk("t5_tie_after_reset", 32'(served[0]), 32'h0);

    // randomized rounds
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(1, 3);
      rand_desc(0);
      rand_desc(1);
      run_round(r[0], r[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
